qos_vc_scheduler: RTL
=====================

// Module: qos_vc_scheduler
// PURPOSE
//  Egress scheduler for the transaction layer's four virtual-channel FIFOs.
//  Each cycle it picks at most one non-empty VC and pops it, using strict, round-robin or table-weighted order.
//  It drives the output-mux select that is aligned with the FIFO read data, and honours downstream backpressure.
//  Sits between the per-VC FIFOs (EMPTY/POP) and the output FIFO (FULL/PAUSE).
// PARAMETERS
//  NUM_VC      4   number of virtual channels (ID width = 2)
//  NUM_SLOT    16  weighted-table slots; TABLE width = NUM_SLOT*2
// PORTS
//  CLOCK       in   1   single clock, rising edge
//  RESET       in   1   synchronous, active-high
//  SET_INIT    in   1   latch SEL/TABLE, restart pointers
//  SEL         in   2   mode: 00 strict, 01 round-robin, 10 weighted table, 11 = strict
//  TABLE       in   32  16 slots x 2-bit VC id; slot k = TABLE[2k+1:2k]
//  VC_EMPTY    in   4   per-VC FIFO empty flags
//  DEST_PAUSE  in   1   downstream almost-full (PAUSE_STB level); blocks pops
//  POP         out  4   one-hot pop to VC FIFOs (Mealy, same cycle)
//  GNT_ID      out  2   VC popped in previous cycle (mux select, registered)
//  GNT_VALID   out  1   GNT_ID valid (registered copy of |POP)
//  IDLE        out  1   RUN state and all VC_EMPTY high
// BEHAVIOUR
//  - Reset: while RESET=1, POP=0 (forced combinationally). Next edge: state=INIT, GNT_ID=0, GNT_VALID=0.
//    Also at that edge: slot pointer=0, RR pointer=3 (so VC0 is first), mode=00, table=0. IDLE=0.
//  - FSM: INIT -(SET_INIT)-> RUN. RUN -(SET_INIT)-> RUN with re-latch. Any state -(RESET)-> INIT.
//    INIT: POP=0, IDLE=0, config regs hold.
//  - SET_INIT cycle: config latched, pointers reset as at reset, POP=0 that cycle.
//  - Pop qualifier: no pop when state!=RUN, DEST_PAUSE=1, SET_INIT=1, or all VC_EMPTY=1.
//    Otherwise exactly one POP bit high. A VC with VC_EMPTY=1 is never popped.
//  - Strict: lowest-index non-empty VC. No pointer state.
//  - Round-robin: search starts at (rr_ptr+1) mod 4 and takes the first non-empty VC.
//    On pop, rr_ptr <= granted VC.
//  - Weighted table: search slots from slot_ptr, wrapping mod 16, for the first slot whose VC is non-empty.
//    Pop that VC; slot_ptr <= (found slot + 1) mod 16. Work-conserving: empty slots are skipped in the same cycle.
//    Weight of a VC = number of slots holding its id. If no slot references a non-empty VC, POP=0 (not an error).
//  - Pointers only move on an actual pop; DEST_PAUSE freezes them.
//  - Latency: POP is combinational from the registered pointers/state and the current inputs.
//    GNT_ID/GNT_VALID follow one cycle later, aligned with the FIFO registered read data.
//  - IDLE is combinational: (state==RUN) && &VC_EMPTY. It does not consider DEST_PAUSE.
// STRUCTURE
//  - Shared package qos_pkg:
//    - constants: MODE_STRICT=2'b00, MODE_RR=2'b01, MODE_WRR=2'b10, NUM_VC=4, VCID_W=2, NUM_SLOT=16, SLOT_W=4
//    - FSM encodings: ST_INIT, ST_RUN
//  - One sub-module qos_rot_pick #(N): rotating priority encoder.
//    Inputs: req[N-1:0], start index. Outputs: found, index.
//    Instanced N=4 for RR, and N=16 for WRR over per-slot request = ~VC_EMPTY[slot id].
// TESTING
//  1 RESET=1 with VC_EMPTY=0000 -> POP=0 every cycle. After RESET drops, without SET_INIT -> POP=0, IDLE=0.
//  2 SEL=00, SET_INIT, VC_EMPTY=1010 -> POP=0001 every cycle; set VC_EMPTY=1011 -> POP=0100.
//  3 SEL=01, all non-empty -> POP 0001,0010,0100,1000,0001. DEST_PAUSE=1 one cycle mid-sequence -> POP=0, order resumes unchanged.
//  4 SEL=10, TABLE=32'h0000_0000 except slots 1,2=VC1, slot3=VC2, all non-empty, 16 pops
//    -> VC0 x13, VC1 x2, VC2 x1 in slot order. With VC0 empty -> alternation VC1,VC1,VC2 only.
//  5 Grant alignment: pop VC2 at cycle t -> GNT_ID=2, GNT_VALID=1 at t+1. No pop at t+1 -> GNT_VALID=0 at t+2.
//  6 Mid-run: RESET in RUN -> POP=0 immediately, INIT next edge. SET_INIT in RUN with SEL change -> POP=0 that cycle, new mode from next.

Source files
------------

// File: rtl/qos_vc_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qos_pkg
//  Brief    : Shared modes, sizes and FSM encoding for the QoS VC scheduler.
//  Revision : 1.0
// ============================================================================
package qos_pkg;

   localparam logic [1:0] MODE_STRICT = 2'b00;
   localparam logic [1:0] MODE_RR     = 2'b01;
   localparam logic [1:0] MODE_WRR    = 2'b10;

   localparam int NUM_VC   = 4;
   localparam int VCID_W   = 2;
   localparam int NUM_SLOT = 16;
   localparam int SLOT_W   = 4;
   localparam int TABLE_W  = NUM_SLOT * VCID_W;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [NUM_VC-1:0] vc_onehot(input logic [VCID_W-1:0] id);
      logic [NUM_VC-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/qos_vc_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : qos_vc_scheduler_if
//  Brief    : Config, VC FIFO status/pop and grant signals of the scheduler.
//  Revision : 1.0
// ============================================================================
interface qos_vc_scheduler_if;
   import qos_pkg::*;

   logic                set_init;
   logic [1:0]          sel;
   logic [TABLE_W-1:0]  slot_table;
   logic [NUM_VC-1:0]   vc_empty;
   logic                dest_pause;
   logic [NUM_VC-1:0]   pop;
   logic [VCID_W-1:0]   gnt_id;
   logic                gnt_valid;
   logic                idle;

   modport master (
      input  set_init, sel, slot_table, vc_empty, dest_pause,
      output pop, gnt_id, gnt_valid, idle
   );

   modport slave (
      output set_init, sel, slot_table, vc_empty, dest_pause,
      input  pop, gnt_id, gnt_valid, idle
   );

endinterface
`default_nettype wire

// File: rtl/qos_vc_scheduler_rot_pick.sv
`default_nettype none
// ============================================================================
//  Module   : qos_rot_pick
//  Brief    : Rotating priority encoder: first set req bit at or after start.
//  Revision : 1.0
// ============================================================================
module qos_rot_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  wire logic [N-1:0]     req,
   input  wire logic [IDX_W-1:0] start,
   output logic                  found,
   output logic [IDX_W-1:0]      idx
);

   logic [IDX_W-1:0] cand;

   // N is a power of two, so the IDX_W-bit add wraps modulo N by itself.
   always_comb begin
      found = 1'b0;
      idx   = start;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = start + IDX_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/qos_vc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : qos_vc_scheduler
//  Brief    : Pops one non-empty VC FIFO per cycle (strict / RR / weighted table).
//  Revision : 1.0
// ============================================================================
module qos_vc_scheduler
   import qos_pkg::*;
(
   input  wire logic           clk,
   input  wire logic           rst,
   qos_vc_scheduler_if.master  bus
);

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [TABLE_W-1:0]  table_q, table_d;
   logic [VCID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SLOT_W-1:0]   slot_ptr_q, slot_ptr_d;
   logic [VCID_W-1:0]   gnt_id_q, gnt_id_d;
   logic                gnt_valid_q, gnt_valid_d;

   logic [NUM_VC-1:0]   pop;
   logic                idle;
   logic [NUM_VC-1:0]   vc_req;
   logic [NUM_SLOT-1:0] slot_req;
   logic [VCID_W-1:0]   rr_start;
   logic                rr_found, wrr_found, strict_found, pick_found;
   logic [VCID_W-1:0]   rr_vc, wrr_vc, strict_vc, pick_vc;
   logic [SLOT_W-1:0]   wrr_slot;

   assign vc_req   = ~bus.vc_empty;
   assign rr_start = rr_ptr_q + VCID_W'(1);

   always_comb begin
      slot_req = '0;
      for (int s = 0; s < NUM_SLOT; s++) begin
         slot_req[s] = vc_req[table_q[s*VCID_W +: VCID_W]];
      end
   end

   qos_rot_pick #(.N(NUM_VC)) u_rr_pick (
      .req   (vc_req),
      .start (rr_start),
      .found (rr_found),
      .idx   (rr_vc)
   );

   qos_rot_pick #(.N(NUM_SLOT)) u_wrr_pick (
      .req   (slot_req),
      .start (slot_ptr_q),
      .found (wrr_found),
      .idx   (wrr_slot)
   );

   assign wrr_vc = table_q[wrr_slot*VCID_W +: VCID_W];

   always_comb begin
      strict_vc = '0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         if (vc_req[i]) strict_vc = VCID_W'(i);
      end
   end
   assign strict_found = |vc_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         mode_q      <= MODE_STRICT;
         table_q     <= '0;
         rr_ptr_q    <= VCID_W'(NUM_VC - 1);
         slot_ptr_q  <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         table_q     <= table_d;
         rr_ptr_q    <= rr_ptr_d;
         slot_ptr_q  <= slot_ptr_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      table_d     = table_q;
      rr_ptr_d    = rr_ptr_q;
      slot_ptr_d  = slot_ptr_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = 1'b0;
      pop         = '0;
      idle        = (state_q == ST_RUN) && (&bus.vc_empty);

      case (mode_q)
         MODE_RR: begin
            pick_found = rr_found;
            pick_vc    = rr_vc;
         end
         MODE_WRR: begin
            pick_found = wrr_found;
            pick_vc    = wrr_vc;
         end
         default: begin
            pick_found = strict_found;
            pick_vc    = strict_vc;
         end
      endcase

      // Reset gates the pop combinationally so the FIFOs never see a pop while it is held.
      if (!rst && (state_q == ST_RUN) && !bus.dest_pause && !bus.set_init && pick_found) begin
         pop         = vc_onehot(pick_vc);
         gnt_valid_d = 1'b1;
         gnt_id_d    = pick_vc;
         if (mode_q == MODE_RR)  rr_ptr_d   = pick_vc;
         if (mode_q == MODE_WRR) slot_ptr_d = wrr_slot + SLOT_W'(1);
      end

      if (bus.set_init) begin
         state_d    = ST_RUN;
         mode_d     = bus.sel;
         table_d    = bus.slot_table;
         rr_ptr_d   = VCID_W'(NUM_VC - 1);
         slot_ptr_d = '0;
      end
   end

   assign bus.pop       = pop;
   assign bus.idle      = idle;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;

endmodule
`default_nettype wire
